// File: rtl/snn_layer1_scheduler_pkg.sv
// snn_layer1_scheduler_pkg: FSM state encoding and default neuron constants
package snn_layer1_scheduler_pkg;
  localparam int DEF_VW = 12;
  localparam int DEF_THRESH = 64;
  localparam int DEF_LEAK = 1;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ACC, S_DONE} state_t;
endpackage

// File: rtl/snn_layer1_scheduler_membrane_update.sv
// snn_membrane_update: saturating leaky membrane update and threshold compare
module snn_membrane_update #(
  parameter int VW = 12,
  parameter int WIDTH = 8,
  parameter int THRESH = 64,
  parameter int LEAK = 1
) (
  input  logic signed [VW-1:0]    i_v,
  input  logic signed [WIDTH-1:0] i_mac_sum,
  output logic signed [VW-1:0]    o_v,
  output logic                    o_fire
);
  localparam int EW = VW + 2;
  localparam logic signed [EW-1:0] VMAX = EW'((2 ** (VW - 1)) - 1);
  localparam logic signed [EW-1:0] VMIN = EW'(-(2 ** (VW - 1)));
  localparam logic signed [VW-1:0] TH = VW'(THRESH);
  logic signed [EW-1:0] w_sum;
  // two guard bits keep the raw sum exact before clamping
  assign w_sum = EW'(i_v) + EW'(i_mac_sum) - EW'(LEAK);
  assign o_v = w_sum > VMAX ? VW'(VMAX) : w_sum < VMIN ? VW'(VMIN) : VW'(w_sum);
  assign o_fire = o_v >= TH;
endmodule

// File: rtl/snn_layer1_scheduler.sv
// snn_layer1_scheduler: time-multiplexes one shared 25-input MAC across the
// layer-1 neurons for a single timestep, then thresholds and emits spikes.
module snn_layer1_scheduler import snn_layer1_scheduler_pkg::*; #(
  parameter int N_NEURONS = 10,
  parameter int S = 25,
  parameter int WIDTH = 8,
  parameter int VW = DEF_VW,
  parameter int THRESH = DEF_THRESH,
  parameter int LEAK = DEF_LEAK,
  parameter int AW = $clog2(N_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear_mem,
  input  logic [S-1:0]           pixels_in,
  output logic                   busy,
  output logic                   done,
  output logic                   w_en,
  output logic [AW-1:0]          w_addr,
  input  logic [S*WIDTH-1:0]     w_rdata,
  output logic [S-1:0]           mac_pixels,
  output logic [S*WIDTH-1:0]     mac_weights,
  input  logic [WIDTH-1:0]       mac_sum,
  output logic [N_NEURONS-1:0]   spike_out
);
  state_t r_state, w_state_nxt;
  logic [AW-1:0] r_idx;
  logic signed [VW-1:0] r_v [N_NEURONS];
  logic [N_NEURONS-1:0] r_spike_nxt, r_spike_out, w_spike_all;
  logic [S-1:0] r_pix;
  logic [S*WIDTH-1:0] r_wts;
  logic signed [VW-1:0] w_v_new;
  logic w_fire, w_last;

  assign w_last = r_idx == AW'(N_NEURONS - 1);
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign w_en = r_state == S_FETCH;
  assign w_addr = r_idx;
  assign mac_pixels = r_pix;
  assign mac_weights = r_wts;
  assign spike_out = r_spike_out;

  snn_membrane_update #(.VW(VW), .WIDTH(WIDTH), .THRESH(THRESH), .LEAK(LEAK)) u_update (
    .i_v(r_v[r_idx]),
    .i_mac_sum($signed(mac_sum)),
    .o_v(w_v_new),
    .o_fire(w_fire)
  );

  always_comb begin
    w_spike_all = r_spike_nxt;
    w_spike_all[r_idx] = w_fire;
    w_state_nxt = r_state == S_IDLE  ? (start ? S_FETCH : S_IDLE) :
                  r_state == S_FETCH ? S_WAIT :
                  r_state == S_WAIT  ? S_ACC :
                  r_state == S_ACC   ? (w_last ? S_DONE : S_FETCH) : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;

  // spike_out is loaded on entry to DONE so it is already valid while done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_pix <= '0;
      r_wts <= '0;
      r_spike_nxt <= '0;
      r_spike_out <= '0;
      for (int i = 0; i < N_NEURONS; i++) r_v[i] <= '0;
    end else begin
      if (r_state == S_IDLE && clear_mem)
        for (int i = 0; i < N_NEURONS; i++) r_v[i] <= '0;
      if (r_state == S_IDLE && start) begin
        r_pix <= pixels_in;
        r_idx <= '0;
      end
      if (r_state == S_WAIT) r_wts <= w_rdata;
      if (r_state == S_ACC) begin
        r_v[r_idx] <= w_fire ? '0 : w_v_new;
        r_spike_nxt[r_idx] <= w_fire;
        if (w_last) r_spike_out <= w_spike_all;
        else r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_snn_layer1_scheduler.sv
// tb_snn_layer1_scheduler: directed checks with behavioural MAC and 1-cycle weight ROM
module tb_snn_layer1_scheduler;
  localparam int N = 10, S = 25, W = 8;
  logic clk = 0, rst_n = 0, start = 0, clear_mem = 0;
  logic [S-1:0] pixels_in = '0;
  logic busy, done, w_en;
  logic [3:0] w_addr;
  logic [S*W-1:0] w_rdata = '0, mac_weights;
  logic [S-1:0] mac_pixels;
  logic [W-1:0] mac_sum;
  logic [N-1:0] spike_out;
  logic [S*W-1:0] rom [N];
  int n_pass = 0, n_total = 0, n_done = 0, lat, cnt, d0;

  always #5 clk = ~clk;

  snn_layer1_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_mem(clear_mem),
    .pixels_in(pixels_in), .busy(busy), .done(done), .w_en(w_en),
    .w_addr(w_addr), .w_rdata(w_rdata), .mac_pixels(mac_pixels),
    .mac_weights(mac_weights), .mac_sum(mac_sum), .spike_out(spike_out)
  );

  always @(posedge clk) if (w_en) w_rdata <= rom[w_addr];

  always_comb begin
    mac_sum = '0;
    for (int i = 0; i < S; i++) if (mac_pixels[i]) mac_sum = mac_sum + mac_weights[i*W +: W];
  end

  always @(negedge clk) if (done) n_done++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic rom_all(input logic [S*W-1:0] row);
    for (int i = 0; i < N; i++) rom[i] = row;
  endtask

  task automatic run_step(input logic clr, output int l);
    @(negedge clk);
    start = 1;
    clear_mem = clr;
    @(posedge clk);
    #1 start = 0;
    clear_mem = 0;
    l = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        l = c;
        break;
      end
    end
    @(posedge clk);
    #1 chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    rom_all('0);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wen", int'(w_en), 0);
    chk("rst_spike", int'(spike_out), 0);
    chk("rst_waddr", int'(w_addr), 0);
    chk("rst_pix", int'(mac_pixels), 0);
    chk("rst_wts", int'(mac_weights != '0), 0);
    rst_n = 1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (w_en) cnt++;
    end
    chk("idle_no_wen", cnt, 0);

    // single fire: neuron 3 sees 25*3 = 75
    rom[3] = {S{8'd3}};
    pixels_in = '1;
    run_step(0, lat);
    chk("fire_latency", lat, 30);
    chk("fire_spike", int'(spike_out), 32'h008);
    chk("fire_v3", dut.r_v[3], 0);
    chk("fire_v0", dut.r_v[0], -1);
    chk("fire_v9", dut.r_v[9], -1);
    chk("fire_busy_low", int'(busy), 0);
    chk("fire_waddr_hold", int'(w_addr), 9);

    @(negedge clk) clear_mem = 1;
    @(negedge clk) clear_mem = 0;
    chk("clear_v9", dut.r_v[9], 0);

    // accumulate: neuron 0 row sums to 20
    rom_all('0);
    rom[0] = {{(S-1){8'd0}}, 8'd20};
    run_step(0, lat);
    chk("acc1_v0", dut.r_v[0], 19);
    chk("acc1_spike", int'(spike_out), 0);
    run_step(0, lat);
    chk("acc2_v0", dut.r_v[0], 38);
    run_step(0, lat);
    chk("acc3_v0", dut.r_v[0], 57);
    chk("acc3_spike", int'(spike_out), 0);
    run_step(0, lat);
    chk("acc4_spike", int'(spike_out), 1);
    chk("acc4_v0", dut.r_v[0], 0);
    chk("acc4_v1", dut.r_v[1], -4);

    // negative saturation: every neuron sees -128
    @(negedge clk) clear_mem = 1;
    @(negedge clk) clear_mem = 0;
    rom_all({{(S-1){8'd0}}, 8'h80});
    run_step(0, lat);
    chk("neg1_v0", dut.r_v[0], -129);
    repeat (19) run_step(0, lat);
    chk("sat_latency", lat, 30);
    chk("sat_v0", dut.r_v[0], -2048);
    chk("sat_v9", dut.r_v[9], -2048);
    chk("sat_spike", int'(spike_out), 0);

    // start/clear mid-run ignored
    rom_all('0);
    rom[3] = {S{8'd3}};
    d0 = n_done;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    @(negedge clk) begin
      start = 1;
      clear_mem = 1;
    end
    @(negedge clk) begin
      start = 0;
      clear_mem = 0;
    end
    repeat (80) @(negedge clk);
    chk("ignore_one_done", n_done - d0, 1);
    chk("ignore_v0", dut.r_v[0], -2048);
    chk("ignore_v3", dut.r_v[3], -1974);
    chk("ignore_spike", int'(spike_out), 0);

    // clear and start together: zeroed potentials, first result repeats
    run_step(1, lat);
    chk("clrstart_latency", lat, 30);
    chk("clrstart_spike", int'(spike_out), 32'h008);
    chk("clrstart_v3", dut.r_v[3], 0);
    chk("clrstart_v0", dut.r_v[0], -1);

    // reset in cycle k+14
    d0 = n_done;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (13) @(posedge clk);
    #1 chk("midrst_busy_before", int'(busy), 1);
    rst_n = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_spike", int'(spike_out), 0);
    chk("midrst_v3", dut.r_v[3], 0);
    chk("midrst_v0", dut.r_v[0], 0);
    chk("midrst_pix", int'(mac_pixels), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
